// File: rtl/fast_karatsuba_mul.sv
// Four-stage unsigned WIDTH x WIDTH multiplier built on one level of Karatsuba.
// Define FAST_KARATSUBA_HOLD_EN to load each stage's data registers only on valid.
module fast_karatsuba_mul #(
  parameter int WIDTH = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 in_valid,
  output logic [2*WIDTH-1:0]   P,
  output logic                 out_valid
);

  localparam int H = WIDTH / 2;

  // stage 1: operand halves and half sums (carry kept)
  logic [H-1:0]     x0_q, x1_q, y0_q, y1_q;
  logic [H:0]       sx_q, sy_q;
  logic             v1_q;

  // stage 2: partial products
  logic [2*H-1:0]   z0_q2, z2_q2;
  logic [2*H+1:0]   zm_q2;
  logic             v2_q;

  // stage 3: outer terms and middle term
  logic [2*H-1:0]   z0_q3, z2_q3;
  logic [2*H+1:0]   z1_q3;
  logic             v3_q;

  logic             ld1, ld2, ld3, ld4;

`ifdef FAST_KARATSUBA_HOLD_EN
  assign ld1 = in_valid;
  assign ld2 = v1_q;
  assign ld3 = v2_q;
  assign ld4 = v3_q;
`else
  assign ld1 = 1'b1;
  assign ld2 = 1'b1;
  assign ld3 = 1'b1;
  assign ld4 = 1'b1;
`endif

  logic [H:0]       sx_d, sy_d;
  logic [2*H-1:0]   z0_d, z2_d;
  logic [2*H+1:0]   zm_d, z1_d;
  logic [2*WIDTH-1:0] p_d;

  always_comb begin
    sx_d = {1'b0, X[H-1:0]} + {1'b0, X[WIDTH-1:H]};
    sy_d = {1'b0, Y[H-1:0]} + {1'b0, Y[WIDTH-1:H]};
    z0_d = {{H{1'b0}}, x0_q} * {{H{1'b0}}, y0_q};
    z2_d = {{H{1'b0}}, x1_q} * {{H{1'b0}}, y1_q};
    zm_d = {{(H+1){1'b0}}, sx_q} * {{(H+1){1'b0}}, sy_q};
    // ZM >= Z0 + Z2 always, so the middle term never wraps
    z1_d = zm_q2 - {2'b00, z0_q2} - {2'b00, z2_q3_src()};
    p_d  = {z2_q3, z0_q3}
         + ({{(2*WIDTH-2*H-2){1'b0}}, z1_q3} << H);
  end

  function automatic logic [2*H-1:0] z2_q3_src();
    return z2_q2;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      v1_q      <= 1'b0;
      z0_q2     <= '0;
      z2_q2     <= '0;
      zm_q2     <= '0;
      v2_q      <= 1'b0;
      z0_q3     <= '0;
      z2_q3     <= '0;
      z1_q3     <= '0;
      v3_q      <= 1'b0;
      P         <= '0;
      out_valid <= 1'b0;
    end else begin
      v1_q      <= in_valid;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      out_valid <= v3_q;
      if (ld1) begin
        x0_q <= X[H-1:0];
        x1_q <= X[WIDTH-1:H];
        y0_q <= Y[H-1:0];
        y1_q <= Y[WIDTH-1:H];
        sx_q <= sx_d;
        sy_q <= sy_d;
      end
      if (ld2) begin
        z0_q2 <= z0_d;
        z2_q2 <= z2_d;
        zm_q2 <= zm_d;
      end
      if (ld3) begin
        z0_q3 <= z0_q2;
        z2_q3 <= z2_q2;
        z1_q3 <= z1_d;
      end
      if (ld4) begin
        P <= p_d;
      end
    end
  end

endmodule

// File: tb/tb_fast_karatsuba_mul.sv
// Scoreboard bench for fast_karatsuba_mul: products queued at drive time, popped on out_valid.
module tb_fast_karatsuba_mul;

  localparam int W = 256;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   X = '0;
  logic [W-1:0]   Y = '0;
  logic           in_valid = 1'b0;
  logic [2*W-1:0] P;
  logic           out_valid;

  fast_karatsuba_mul #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .X         (X),
    .Y         (Y),
    .in_valid  (in_valid),
    .P         (P),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb[$];
  logic [3:0]     vhist;
  logic [2*W-1:0] last_p = '0;

  task automatic check_val(input string tag, input logic [2*W-1:0] obs,
                           input logic [2*W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // expected out_valid: in_valid seen on four successive capturing edges
  always @(posedge clock or negedge reset) begin
    if (!reset) vhist <= 4'd0;
    else        vhist <= {vhist[2:0], in_valid};
  end

  always @(negedge clock) begin
    if (!reset) begin
      check_val("rst_p", P, '0);
      check_val("rst_vld", {511'd0, out_valid}, '0);
      last_p = '0;
    end else begin
      check_val("vld_timing", {511'd0, out_valid}, {511'd0, vhist[3]});
      if (out_valid) begin
        if (sb.size() == 0) begin
          check_val("sb_underflow", 512'(sb.size()), 512'd1);
        end else begin
          logic [2*W-1:0] e;
          e = sb.pop_front();
          check_val("product", P, e);
          last_p = e;
        end
      end
`ifdef FAST_KARATSUBA_HOLD_EN
      else begin
        check_val("p_hold", P, last_p);
      end
`endif
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic v, input logic [2*W-1:0] exp);
    X = x;
    Y = y;
    in_valid = v;
    if (v && reset) sb.push_back(exp);
    tick();
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ones, one, a, b;
    logic [2*W-1:0] ones_sq;
    logic [4:0] pat;
    ones = '1;
    one  = 1;
    ones_sq = {{63{4'hF}}, 4'hE, {63{4'h0}}, 4'h1};

    // reset held with all-ones operands presented
    X = ones; Y = ones; in_valid = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    in_valid = 1'b0;

    drive(256'd2, 256'd3, 1'b1, 512'd6);
    repeat (6) drive('0, '0, 1'b0, '0);

    drive(ones, ones, 1'b1, ones_sq);
    a = one << 128;
    drive(a, a, 1'b1, 512'd1 << 256);
    a = (one << 128) - 1;
    b = one << 255;
    drive(a, b, 1'b1, ref_mul(a, b));
    drive('0, ones, 1'b1, '0);
    drive(one, ones, 1'b1, {256'd0, ones});
    repeat (6) drive('0, '0, 1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      a = rand_w();
      b = rand_w();
      drive(a, b, 1'b1, ref_mul(a, b));
    end
    repeat (6) drive(rand_w(), rand_w(), 1'b0, '0);

    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      a = rand_w();
      b = rand_w();
      drive(a, b, pat[i], ref_mul(a, b));
    end
    repeat (6) drive('0, '0, 1'b0, '0);

    // mid-stream reset: in-flight products must vanish
    for (int i = 0; i < 3; i++) begin
      a = rand_w();
      b = rand_w();
      drive(a, b, 1'b1, ref_mul(a, b));
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_val("rst_async_vld", {511'd0, out_valid}, '0);
    check_val("rst_async_p", P, '0);
    sb.delete();
    tick();
    reset = 1'b1;
    repeat (6) drive('0, '0, 1'b0, '0);

    a = rand_w();
    b = rand_w();
    drive(a, b, 1'b1, ref_mul(a, b));
    repeat (8) drive('0, '0, 1'b0, '0);

    check_val("sb_drain", 512'(sb.size()), 512'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_karatsuba_mul.md
Name: fast_karatsuba_mul

Overview:
- Fully pipelined unsigned 256x256 -> 512-bit multiplier using one level of Karatsuba decomposition.
- Used as the wide-product core feeding the modular reduction stage of the modular multiplier datapath.
- Accepts one operand pair per clock and produces one product per clock after a fixed latency.

Parameters:
- WIDTH, 256, operand width in bits; must be even. Half width H = WIDTH/2.
- LATENCY, 4, fixed pipeline depth in cycles. Informational only; the RTL must equal 4 and must not be overridden.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- X  input  WIDTH  unsigned multiplicand.
- Y  input  WIDTH  unsigned multiplier.
- in_valid  input  1  X/Y valid, sampled on the rising clock edge.
- P  output  2*WIDTH  registered product X*Y.
- out_valid  output  1  P holds a valid product this cycle.

Behaviour:
- Reset (reset=0, asynchronous): every valid flag clears, P=0, out_valid=0. All pipeline data registers clear to 0.
- After reset releases, operation starts at the next rising edge.
- Mid-operation reset discards all in-flight products. No stale out_valid may appear after release.
- Handshake: no backpressure. A pair is captured at every edge where in_valid=1. in_valid=0 inserts a bubble.
- out_valid equals in_valid delayed by exactly 4 edges. P then equals the X*Y captured on that edge.
- Back-to-back inputs give back-to-back outputs in order.
- Arithmetic (unsigned). Split X = X1*2^H + X0 and Y = Y1*2^H + Y0.
- Stage 1 registers:
  - X0, X1, Y0, Y1;
  - SX = X0 + X1 and SY = Y0 + Y1, each H+1 bits (carry kept);
  - valid bit.
- Stage 2 registers the three products:
  - Z0 = X0*Y0 (2H bits);
  - Z2 = X1*Y1 (2H bits);
  - ZM = SX*SY (2H+2 bits).
- Stage 3 registers Z0, Z2 and the middle term Z1 = ZM - Z0 - Z2 (2H+2 bits, never negative).
- Stage 4 registers P = Z2*2^WIDTH + Z1*2^H + Z0, truncated to 2*WIDTH bits (no overflow possible), and sets out_valid.
- Carries out of SX/SY and into the top of P must be handled: an all-ones operand must multiply correctly.
- Zero or one operands need no special case.
- Without the optional feature, all data registers load every cycle regardless of valid. P may change while out_valid=0; downstream must qualify P with out_valid.

Optional Feature:
- Macro FAST_KARATSUBA_HOLD_EN.
- Defined: each stage's data registers load only when that stage's incoming valid bit is 1. P holds the last valid product while out_valid=0 and stays 0 until the first product after reset.
- Undefined: free-running data path as described in Behaviour.
- Valid timing and latency are identical in both builds.

Test Plan:
- Reset with reset=0 and X=Y=all-ones, in_valid=1 -> P=0, out_valid=0 throughout. After release, first out_valid occurs exactly 4 edges after the first captured pair.
- Single pair X=2, Y=3, then bubbles -> exactly one out_valid pulse with P=6.
- X=Y=2^256-1 -> P = 2^512-2^257+1, i.e. 63 hex F, one hex E, 63 hex 0, one hex 1. Checks the SX/SY carry path.
- X=Y=2^128 -> P=2^256. X=2^128-1, Y=2^255 -> P=(2^128-1)*2^255.
- Ten random 256-bit pairs on consecutive cycles -> ten consecutive out_valid cycles, each P equal to the reference X*Y in input order. Then out_valid=0.
- Pairs with in_valid toggling 1,0,1,1,0 -> out_valid pattern 1,0,1,1,0 after 4 cycles. reset pulsed low mid-stream -> out_valid=0 immediately, with no results from pre-reset inputs afterward.
- FAST_KARATSUBA_HOLD_EN build only: P stays constant during output bubbles.
